// File: rtl/io_seq_pkg.sv
// Shared types for the ready-driven operand sequencer.
// Holds the sequencer state encoding and the LED reset value.
package io_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_X,
    WAIT_XLO,
    WAIT_Y,
    WAIT_YLO,
    CALC,
    SHOW_X,
    SHOW_Y
  } seq_state_t;

  localparam logic LED_RST_BIT = 1'b0;

endpackage

// File: rtl/ready_sync_edge.sv
// Two-flop synchronizer plus optional debounce (READY_DEBOUNCE_EN) and edge detector.
// Ports: clk, reset (async active-low), din in; level, rise, fall out.
module ready_sync_edge #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic lvl_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      lvl_q <= 1'b0;
    end else begin
      s1    <= din;
      s2    <= s1;
      lvl_q <= level;
    end
  end

`ifdef READY_DEBOUNCE_EN
  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          deb;
  logic [CW-1:0] cnt;

  // deb only follows s2 once it has differed for
  // DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb <= 1'b0;
      cnt <= '0;
    end else if (s2 == deb) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      deb <= s2;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign level = deb;
`else
  assign level = s2;
`endif

  assign rise = level & ~lvl_q;
  assign fall = ~level & lvl_q;

endmodule

// File: rtl/ready_input_sequencer.sv
// Captures two operands from sw on ready handshakes, starts a compute, shows results.
// Ports: clk, reset(n), sw, ready, x_out, y_out, start, res_*, LED, busy. Macro READY_DEBOUNCE_EN.
module ready_input_sequencer
  import io_seq_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  input  logic             ready,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic             start,
  input  logic [WIDTH-1:0] res_x,
  input  logic [WIDTH-1:0] res_y,
  input  logic             res_valid,
  output logic [WIDTH-1:0] LED,
  output logic             busy
);

  seq_state_t       state;
  seq_state_t       state_n;
  logic             rdy_lvl;
  logic             rise;
  logic             fall;
  logic             res_acc;
  logic [WIDTH-1:0] ry_q;

  ready_sync_edge #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .din  (ready),
    .level(rdy_lvl),
    .rise (rise),
    .fall (fall)
  );

  // A result arriving while start is still high is
  // too early to belong to this request.
  assign res_acc = (state == CALC) & res_valid & ~start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= WAIT_X;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      WAIT_X:   if (rise)    state_n = WAIT_XLO;
      WAIT_XLO: if (fall)    state_n = WAIT_Y;
      WAIT_Y:   if (rise)    state_n = WAIT_YLO;
      WAIT_YLO: if (fall)    state_n = CALC;
      CALC:     if (res_acc) state_n = SHOW_X;
      SHOW_X:   if (rise)    state_n = SHOW_Y;
      SHOW_Y:   if (fall)    state_n = WAIT_X;
      default:               state_n = WAIT_X;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_out <= '0;
      y_out <= '0;
      ry_q  <= '0;
      LED   <= {WIDTH{LED_RST_BIT}};
      start <= 1'b0;
      busy  <= 1'b0;
    end else begin
      start <= 1'b0;
      unique case (state)
        WAIT_X: if (rise) begin
          x_out <= sw;
          LED   <= sw;
        end
        WAIT_Y: if (rise) begin
          y_out <= sw;
          LED   <= sw;
        end
        WAIT_YLO: if (fall) begin
          start <= 1'b1;
          busy  <= 1'b1;
        end
        CALC: if (res_acc) begin
          ry_q <= res_y;
          LED  <= res_x;
          busy <= 1'b0;
        end
        SHOW_X: if (rise) LED <= ry_q;
        default: ;
      endcase
    end
  end

  logic unused_lvl;
  assign unused_lvl = rdy_lvl;

endmodule

// File: tb/tb_ready_input_sequencer.sv
// Directed self-checking bench for ready_input_sequencer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ready_input_sequencer;

  localparam int W   = 8;
  localparam int DEB = 4;
`ifdef READY_DEBOUNCE_EN
  localparam int LAT = DEB + 6;
`else
  localparam int LAT = 4;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] sw;
  logic         ready;
  logic [W-1:0] x_out;
  logic [W-1:0] y_out;
  logic         start;
  logic [W-1:0] res_x;
  logic [W-1:0] res_y;
  logic         res_valid;
  logic [W-1:0] LED;
  logic         busy;

  int checks = 0;
  int passed = 0;
  int starts = 0;

  ready_input_sequencer #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sw       (sw),
    .ready    (ready),
    .x_out    (x_out),
    .y_out    (y_out),
    .start    (start),
    .res_x    (res_x),
    .res_y    (res_y),
    .res_valid(res_valid),
    .LED      (LED),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (start) starts <= starts + 1;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ready(input logic v);
    ready = v;
    cyc(LAT);
  endtask

  task automatic pulse_res(input logic [W-1:0] rx,
                           input logic [W-1:0] ry);
    res_x = rx;
    res_y = ry;
    res_valid = 1'b1;
    cyc(1);
    res_valid = 1'b0;
    cyc(2);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #50;
    @(negedge clk);
    reset = 1'b1;
    cyc(2);
  endtask

  task automatic test_reset();
    sw = '0; ready = 1'b0; res_x = '0; res_y = '0;
    res_valid = 1'b0;
    do_reset();
    checks++;
    if (LED !== 8'd0) $display("FAIL reset_led got %0d want 0", LED);
    else passed++;
    checks++;
    if (x_out !== 8'd0) $display("FAIL reset_x got %0d want 0", x_out);
    else passed++;
    checks++;
    if (y_out !== 8'd0) $display("FAIL reset_y got %0d want 0", y_out);
    else passed++;
    checks++;
    if (start !== 1'b0) $display("FAIL reset_start got %b want 0", start);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
    else passed++;
  endtask

  task automatic test_capture();
    int s0;
    s0 = starts;
    sw = 8'd4;
    set_ready(1'b1);
    checks++;
    if (x_out !== 8'd4) $display("FAIL cap_x got %0d want 4", x_out);
    else passed++;
    checks++;
    if (LED !== 8'd4) $display("FAIL echo_x got %0d want 4", LED);
    else passed++;
    set_ready(1'b0);
    sw = 8'd8;
    set_ready(1'b1);
    checks++;
    if (y_out !== 8'd8) $display("FAIL cap_y got %0d want 8", y_out);
    else passed++;
    checks++;
    if (LED !== 8'd8) $display("FAIL echo_y got %0d want 8", LED);
    else passed++;
    set_ready(1'b0);
    checks++;
    if (starts - s0 !== 1)
      $display("FAIL start_count got %0d want 1", starts - s0);
    else passed++;
    checks++;
    if (busy !== 1'b1) $display("FAIL busy_calc got %b want 1", busy);
    else passed++;
  endtask

  task automatic test_result();
    pulse_res(8'd12, 8'd20);
    checks++;
    if (LED !== 8'd12) $display("FAIL led_rx got %0d want 12", LED);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("FAIL busy_done got %b want 0", busy);
    else passed++;
    set_ready(1'b1);
    checks++;
    if (LED !== 8'd20) $display("FAIL led_ry got %0d want 20", LED);
    else passed++;
    set_ready(1'b0);
    checks++;
    if (LED !== 8'd20) $display("FAIL led_hold got %0d want 20", LED);
    else passed++;
  endtask

  task automatic test_ignore_idle();
    pulse_res(8'd99, 8'd98);
    checks++;
    if (LED !== 8'd20) $display("FAIL idle_res_led got %0d want 20", LED);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("FAIL idle_res_busy got %b want 0", busy);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int  s0;
    bit  seen;
    s0 = starts;
    seen = 1'b0;
    sw = 8'd5;
    set_ready(1'b1);
    checks++;
    if (LED !== 8'd5 || x_out !== 8'd5)
      $display("FAIL t2_x got led %0d x %0d want 5", LED, x_out);
    else passed++;
    set_ready(1'b0);
    sw = 8'd10;
    set_ready(1'b1);
    checks++;
    if (LED !== 8'd10 || y_out !== 8'd10)
      $display("FAIL t2_y got led %0d y %0d want 10", LED, y_out);
    else passed++;
    ready = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc(1);
      if (start === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) $display("FAIL start_timeout got none want pulse");
    else passed++;
    res_x = 8'd77;
    res_y = 8'd78;
    res_valid = 1'b1;
    cyc(1);
    res_valid = 1'b0;
    cyc(2);
    checks++;
    if (busy !== 1'b1 || LED !== 8'd10)
      $display("FAIL start_cycle_res got busy %b led %0d want 1 10",
               busy, LED);
    else passed++;
    set_ready(1'b1);
    set_ready(1'b0);
    checks++;
    if (LED !== 8'd10 || x_out !== 8'd5 || y_out !== 8'd10)
      $display("FAIL calc_ready got led %0d x %0d y %0d want 10 5 10",
               LED, x_out, y_out);
    else passed++;
    checks++;
    if (starts - s0 !== 1)
      $display("FAIL t2_starts got %0d want 1", starts - s0);
    else passed++;
    pulse_res(8'd15, 8'd25);
    checks++;
    if (LED !== 8'd15) $display("FAIL t2_rx got %0d want 15", LED);
    else passed++;
    set_ready(1'b1);
    checks++;
    if (LED !== 8'd25) $display("FAIL t2_ry got %0d want 25", LED);
    else passed++;
    set_ready(1'b0);
  endtask

  task automatic test_reset_mid_calc();
    sw = 8'd3;
    set_ready(1'b1);
    set_ready(1'b0);
    sw = 8'd6;
    set_ready(1'b1);
    set_ready(1'b0);
    checks++;
    if (busy !== 1'b1) $display("FAIL mid_busy got %b want 1", busy);
    else passed++;
    do_reset();
    pulse_res(8'd50, 8'd51);
    checks++;
    if (LED !== 8'd0 || busy !== 1'b0)
      $display("FAIL abandon got led %0d busy %b want 0 0", LED, busy);
    else passed++;
  endtask

  task automatic test_ready_high_reset();
    sw = 8'd9;
    ready = 1'b1;
    do_reset();
    cyc(LAT);
    checks++;
    if (x_out !== 8'd9) $display("FAIL rst_high_x got %0d want 9", x_out);
    else passed++;
    set_ready(1'b0);
  endtask

`ifdef READY_DEBOUNCE_EN
  task automatic test_debounce();
    ready = 1'b0;
    sw = 8'd33;
    do_reset();
    ready = 1'b1;
    cyc(2);
    ready = 1'b0;
    cyc(LAT);
    checks++;
    if (x_out !== 8'd0) $display("FAIL glitch got %0d want 0", x_out);
    else passed++;
    ready = 1'b1;
    cyc(6);
    cyc(LAT);
    checks++;
    if (x_out !== 8'd33) $display("FAIL deb_cap got %0d want 33", x_out);
    else passed++;
    set_ready(1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_capture();
    test_result();
    test_ignore_idle();
    test_back_to_back();
    test_reset_mid_calc();
    test_ready_high_reset();
`ifdef READY_DEBOUNCE_EN
    test_debounce();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ready_input_sequencer.md
READY_INPUT_SEQUENCER -- requirements
Module: ready_input_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of switches, operands, results and LED.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4, number of stable synchronized cycles required on ready when debounce is compiled in.
REQ-003 SHALL have port clk  input  1  single system clock, all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sw  input  WIDTH  operand value set by the user before raising ready.
REQ-006 SHALL have port ready  input  1  asynchronous user handshake level.
REQ-007 SHALL have port x_out  output  WIDTH  captured first operand.
REQ-008 SHALL have port y_out  output  WIDTH  captured second operand.
REQ-009 SHALL have port start  output  1  one-cycle pulse requesting computation on x_out/y_out.
REQ-010 SHALL have port res_x  input  WIDTH  computed x result.
REQ-011 SHALL have port res_y  input  WIDTH  computed y result.
REQ-012 SHALL have port res_valid  input  1  one-cycle pulse qualifying res_x/res_y.
REQ-013 SHALL have port LED  output  WIDTH  display value.
REQ-014 SHALL have port busy  output  1  high from start pulse until res_valid is accepted.

Function
REQ-015 SHALL pass ready through a two-flop synchronizer and derive one-cycle rise and fall pulses from the synchronized level.
REQ-016 SHALL sample sw in the same cycle a rise pulse is acted on, with no sw synchronizer (sw is quasi-static).
REQ-017 SHALL implement states WAIT_X, WAIT_XLO, WAIT_Y, WAIT_YLO, CALC, SHOW_X, SHOW_Y.
REQ-018 WAIT_X: on rise, x_out <= sw, go WAIT_XLO.
REQ-019 WAIT_XLO: on fall, go WAIT_Y.
REQ-020 WAIT_Y: on rise, y_out <= sw, go WAIT_YLO.
REQ-021 WAIT_YLO: on fall, assert start for exactly one cycle, set busy, go CALC.
REQ-022 CALC: ignore ready edges; on res_valid, latch res_x/res_y internally, clear busy, LED <= res_x, go SHOW_X.
REQ-023 SHOW_X: on rise, LED <= latched y result, go SHOW_Y.
REQ-024 SHOW_Y: on fall, go WAIT_X; LED holds the y result until next x capture.
REQ-025 SHALL drive LED <= sw-captured x value on capture in WAIT_X (echo) and y value on capture in WAIT_Y.
REQ-026 Latency without debounce: ready rising at pin SHALL update x_out/y_out no later than the third rising clk edge.
REQ-027 res_valid outside CALC SHALL be ignored; res_valid coincident with the start cycle SHALL be ignored.
REQ-028 Rise and fall pulses SHALL never occur in the same cycle; an edge not expected by the current state SHALL be discarded, not queued.

Reset
REQ-029 On reset low, asynchronously: state WAIT_X, x_out/y_out/LED/result latches = 0, start = 0, busy = 0, synchronizer flops = 0.
REQ-030 Reset asserted mid-CALC SHALL abandon the computation; a later res_valid SHALL be ignored until a new start.
REQ-031 After reset release with ready already high, the synchronizer SHALL produce one rise pulse, capturing x.

Configuration
REQ-032 Macro READY_DEBOUNCE_EN defined: a rise/fall pulse SHALL be issued only after the synchronized ready holds its new level for DEBOUNCE_CYCLES consecutive cycles; shorter glitches produce no pulse.
REQ-033 Macro READY_DEBOUNCE_EN undefined: debounce logic absent, DEBOUNCE_CYCLES unused, latency per REQ-026.

Structure
REQ-034 Package io_seq_pkg SHALL hold the state enum typedef and the reset value constant for LED.
REQ-035 Sub-module ready_sync_edge SHALL contain synchronizer, optional debounce counter and edge detector, outputting level, rise, fall.

Verification
REQ-036 Reset low 50 ns then high, ready=0 -> LED=0, x_out=0, y_out=0, start=0, state WAIT_X.
REQ-037 sw=4, ready rise, fall; sw=8, ready rise, fall -> x_out=4, y_out=8, one start pulse, busy=1.
REQ-038 Model returns res_x=12, res_y=20 with res_valid -> LED=12, busy=0; ready rise -> LED=20; ready fall -> WAIT_X.
REQ-039 Second transaction sw=5 then 10, results 15/25 -> LED sequence 5, 10, 15, 25; no residual data from transaction 1.
REQ-040 Ready toggled during CALC and res_valid pulsed in WAIT_X -> no state change, no LED change.
REQ-041 With READY_DEBOUNCE_EN, 2-cycle ready glitch -> no capture; 6-cycle stable high -> x captured.
